// File: rtl/cnstr_pkg.sv
// Shared types and the per-entry constraint evaluation used by the
// stream checker and its constraint table.
package cnstr_pkg;

  typedef enum logic [1:0] {
    CM_TRUE  = 2'd0,
    CM_NZ    = 2'd1,
    CM_IMPL  = 2'd2,
    CM_FALSE = 2'd3
  } cmode_t;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } st_t;

  function automatic logic cnstr_eval(input cmode_t mode, input logic nz_a, input logic nz_b);
    logic r;
    case (mode)
      CM_TRUE:  r = 1'b1;
      CM_NZ:    r = nz_a;
      CM_IMPL:  r = !nz_a || nz_b;
      CM_FALSE: r = 1'b0;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cnstr_table.sv
// Constraint table: NUM_CONS entries of {mode, a_idx, b_idx}, one write
// port, combinational read by entry index; resets to TRUE entries.
module cnstr_table
  import cnstr_pkg::*;
#(
  parameter int NUM_CONS = 4,
  parameter int IW       = 6,
  parameter int CW       = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [CW-1:0]   i_widx,
  input  logic [2*IW+1:0] i_wdata,
  input  logic [CW-1:0]   i_ridx,
  output cmode_t          o_mode,
  output logic [IW-1:0]   o_a,
  output logic [IW-1:0]   o_b
);

  cmode_t        r_mode [NUM_CONS];
  logic [IW-1:0] r_a    [NUM_CONS];
  logic [IW-1:0] r_b    [NUM_CONS];

  logic w_wr_ok;
  assign w_wr_ok = i_we && (int'(i_widx) < NUM_CONS);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CONS; i++) begin
        r_mode[i] <= CM_TRUE;
        r_a[i]    <= '0;
        r_b[i]    <= '0;
      end
    end else if (w_wr_ok) begin
      r_mode[i_widx] <= cmode_t'(i_wdata[2*IW+1:2*IW]);
      r_a[i_widx]    <= i_wdata[2*IW-1:IW];
      r_b[i_widx]    <= i_wdata[IW-1:0];
    end
  end

  // Reader only ever presents indices below NUM_CONS.
  assign o_mode = r_mode[i_ridx];
  assign o_a    = r_a[i_ridx];
  assign o_b    = r_b[i_ridx];

endmodule

// File: rtl/cnstr_stream_checker.sv
// Streams one candidate frame into nonzero flags, then walks the constraint
// table one entry per cycle and reports the conjunction and first failure.
module cnstr_stream_checker
  import cnstr_pkg::*;
#(
  parameter  int NUM_VARS = 50,
  parameter  int VAR_W    = 8,
  parameter  int NUM_CONS = 4,
  localparam int IW       = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1,
  localparam int CW       = (NUM_CONS > 1) ? $clog2(NUM_CONS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [CW-1:0]   cfg_idx,
  input  logic [2*IW+1:0] cfg_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   in_idx,
  input  logic [VAR_W-1:0] in_data,
  input  logic            in_last,
  output logic            busy,
  output logic            res_valid,
  output logic            res_x,
  output logic [CW-1:0]   res_fail_idx,
  output logic            res_err
);

  localparam int NZ_N = 1 << IW;

  st_t            r_state;
  logic           r_in_ready;
  logic           r_busy;
  logic           r_res_valid;
  logic           r_res_x;
  logic [CW-1:0]  r_res_fail_idx;
  logic           r_res_err;
  // Sized to the full index space so table reads never leave the vector;
  // flags at or above NUM_VARS are never written and read as zero.
  logic [NZ_N-1:0] r_nz;
  logic           r_err_acc;
  logic [CW-1:0]  r_k;
  logic           r_acc;
  logic [CW-1:0]  r_fail_acc;

  cmode_t         w_mode;
  logic [IW-1:0]  w_a;
  logic [IW-1:0]  w_b;
  logic           w_cres;
  logic           w_beat;
  logic           w_idx_ok;
  logic           w_k_last;
  logic           w_cfg_we;

  assign w_cfg_we = cfg_we && !r_busy;

  cnstr_table #(
    .NUM_CONS (NUM_CONS),
    .IW       (IW),
    .CW       (CW)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_cfg_we),
    .i_widx  (cfg_idx),
    .i_wdata (cfg_data),
    .i_ridx  (r_k),
    .o_mode  (w_mode),
    .o_a     (w_a),
    .o_b     (w_b)
  );

  assign w_beat   = in_valid && r_in_ready && (r_state == ST_LOAD);
  assign w_idx_ok = int'(in_idx) < NUM_VARS;
  assign w_k_last = int'(r_k) == (NUM_CONS - 1);
  assign w_cres   = cnstr_eval(w_mode, r_nz[w_a], r_nz[w_b]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_LOAD;
      r_in_ready     <= 1'b1;
      r_busy         <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_x        <= 1'b0;
      r_res_fail_idx <= '0;
      r_res_err      <= 1'b0;
      r_nz           <= '0;
      r_err_acc      <= 1'b0;
      r_k            <= '0;
      r_acc          <= 1'b1;
      r_fail_acc     <= '0;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_beat) begin
            if (w_idx_ok) r_nz[in_idx] <= (in_data != '0);
            else          r_err_acc    <= 1'b1;
            if (in_last) begin
              r_state    <= ST_EVAL;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_k        <= '0;
              r_acc      <= 1'b1;
              r_fail_acc <= '0;
            end
          end
        end
        ST_EVAL: begin
          // Only the first failure is recorded: acc is still 1 at that point.
          if (!w_cres && r_acc) r_fail_acc <= r_k;
          r_acc <= r_acc & w_cres;
          if (w_k_last) r_state <= ST_DONE;
          else          r_k     <= r_k + 1'b1;
        end
        ST_DONE: begin
          r_res_valid    <= 1'b1;
          r_res_x        <= r_acc;
          r_res_fail_idx <= r_fail_acc;
          r_res_err      <= r_err_acc;
          r_nz           <= '0;
          r_err_acc      <= 1'b0;
          r_state        <= ST_LOAD;
          r_in_ready     <= 1'b1;
          r_busy         <= 1'b0;
        end
        default: begin
          r_state    <= ST_LOAD;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign busy         = r_busy;
  assign res_valid    = r_res_valid;
  assign res_x        = r_res_x;
  assign res_fail_idx = r_res_fail_idx;
  assign res_err      = r_res_err;

endmodule

// File: tb/tb_cnstr_stream_checker.sv
// Directed bench for cnstr_stream_checker with NUM_VARS=50, NUM_CONS=4.
module tb_cnstr_stream_checker;

  localparam int NV = 50;
  localparam int NC = 4;
  localparam int IW = 6;
  localparam int CW = 2;
  localparam logic [1:0] M_TRUE = 2'd0, M_NZ = 2'd1, M_IMPL = 2'd2, M_FALSE = 2'd3;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_we;
  logic [CW-1:0]   cfg_idx;
  logic [2*IW+1:0] cfg_data;
  logic            in_valid;
  logic            in_ready;
  logic [IW-1:0]   in_idx;
  logic [7:0]      in_data;
  logic            in_last;
  logic            busy;
  logic            res_valid;
  logic            res_x;
  logic [CW-1:0]   res_fail_idx;
  logic            res_err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  cnstr_stream_checker #(.NUM_VARS(NV), .VAR_W(8), .NUM_CONS(NC)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_data     (cfg_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_idx       (in_idx),
    .in_data      (in_data),
    .in_last      (in_last),
    .busy         (busy),
    .res_valid    (res_valid),
    .res_x        (res_x),
    .res_fail_idx (res_fail_idx),
    .res_err      (res_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*IW+1:0] cword(input logic [1:0] m, input int a, input int b);
    return {m, 6'(a), 6'(b)};
  endfunction

  // All tasks start and end on a falling edge.
  task automatic cfg(input int idx, input logic [1:0] m, input int a, input int b);
    cfg_we   = 1'b1;
    cfg_idx  = 2'(idx);
    cfg_data = cword(m, a, b);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic beat(input int idx, input int data, input logic last);
    in_valid = 1'b1;
    in_idx   = 6'(idx);
    in_data  = 8'(data);
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic ex, input int ef, input logic ee);
    int   n = 0;
    logic saw_ready = 1'b0;
    logic saw_idle  = 1'b0;
    while (!res_valid && n < 20) begin
      if (in_ready) saw_ready = 1'b1;
      if (!busy)    saw_idle  = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, NC + 1);
    chk({tag, "_rdy_eval"}, saw_ready, 1'b0);
    chk({tag, "_busy_eval"}, saw_idle, 1'b0);
    chk({tag, "_x"}, res_x, ex);
    chk({tag, "_fail"}, res_fail_idx, ef);
    chk({tag, "_err"}, res_err, ee);
  endtask

  initial begin
    int vcnt;
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
    in_valid = 1'b0; in_idx = '0; in_data = '0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_x", res_x, 1'b0);
    chk("rst_fail", res_fail_idx, 0);
    chk("rst_err", res_err, 1'b0);

    // Default table: everything TRUE
    beat(0, 5, 1'b1);
    wait_result("def", 1'b1, 0, 1'b0);
    @(negedge clk);
    chk("def_pulse", res_valid, 1'b0);
    chk("def_hold_x", res_x, 1'b1);
    chk("def_ready_after", in_ready, 1'b1);

    // IMPL(0 -> 38) in entry 0
    cfg(0, M_IMPL, 0, 38);
    beat(0, 3, 1'b0); beat(38, 0, 1'b1);
    wait_result("impl_f", 1'b0, 0, 1'b0);
    beat(0, 3, 1'b0); beat(38, 4, 1'b1);
    wait_result("impl_t", 1'b1, 0, 1'b0);
    beat(38, 0, 1'b1);
    wait_result("impl_abs", 1'b1, 0, 1'b0);

    // Several failing entries: lowest index is reported
    cfg(0, M_TRUE, 0, 0); cfg(1, M_FALSE, 0, 0); cfg(3, M_NZ, 7, 0);
    beat(7, 0, 1'b1);
    wait_result("multi", 1'b0, 1, 1'b0);
    cfg(1, M_TRUE, 0, 0);
    beat(7, 0, 1'b1);
    wait_result("only3", 1'b0, 3, 1'b0);
    beat(7, 200, 1'b1);
    wait_result("nz7", 1'b1, 0, 1'b0);
    cfg(3, M_TRUE, 0, 0);

    // Out-of-range index and flag clearing between frames
    cfg(0, M_NZ, 5, 0);
    beat(5, 9, 1'b0); beat(60, 1, 1'b1);
    wait_result("oor", 1'b1, 0, 1'b1);
    beat(2, 1, 1'b1);
    wait_result("clear", 1'b0, 0, 1'b0);
    cfg(0, M_NZ, 49, 0);
    beat(49, 1, 1'b1);
    wait_result("idx49", 1'b1, 0, 1'b0);
    cfg(0, M_NZ, 5, 0);
    beat(5, 1, 1'b0); beat(5, 0, 1'b1);
    wait_result("rewrite", 1'b0, 0, 1'b0);

    // Config write held through EVAL/DONE is dropped
    cfg(0, M_TRUE, 0, 0);
    beat(0, 0, 1'b1);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_data = cword(M_FALSE, 0, 0);
    wait_result("cfg_busy", 1'b1, 0, 1'b0);
    cfg_we = 1'b0;
    beat(0, 0, 1'b1);
    wait_result("cfg_kept", 1'b1, 0, 1'b0);

    // Config write coincident with the last beat is seen by EVAL
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_data = cword(M_FALSE, 0, 0);
    beat(0, 0, 1'b1);
    cfg_we = 1'b0;
    wait_result("cfg_last", 1'b0, 2, 1'b0);
    cfg(2, M_TRUE, 0, 0);

    // Empty frame with nonzero result fields, then reset mid-EVAL
    cfg(3, M_FALSE, 0, 0);
    beat(60, 0, 1'b1);
    wait_result("empty", 1'b0, 3, 1'b1);
    beat(0, 1, 1'b1);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_ready", in_ready, 1'b1);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_fail", res_fail_idx, 0);
    chk("mrst_err", res_err, 1'b0);
    chk("mrst_x", res_x, 1'b0);
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid) vcnt++;
      @(negedge clk);
    end
    chk("mrst_novalid", vcnt, 0);
    beat(0, 0, 1'b1);
    wait_result("mrst_table", 1'b1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
